// File: rtl/tff_pulse_sched_if.sv
// Request/grant and T-pulse bundle for tff_pulse_sched.
// master: requesting control logic; slave: the scheduler.
interface tff_pulse_sched_if #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned CNT_W = 8
);
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gnt;
   logic             t_pulse;
   logic             busy;
   logic             t_state;
   logic [CNT_W-1:0] pulse_cnt;

   modport master (
      output req,
      input  gnt,
      input  t_pulse,
      input  busy,
      input  t_state,
      input  pulse_cnt
   );

   modport slave (
      input  req,
      output gnt,
      output t_pulse,
      output busy,
      output t_state,
      output pulse_cnt
   );
endinterface

// File: rtl/tff_pulse_sched.sv
// Round-robin scheduler sharing one T flip-flop pulse input among N_REQ requesters.
// Emits PULSE_W-cycle pulses whose rising edges are at least SEP_CYC cycles apart,
// mirrors the flip-flop state and optionally counts issued pulses.
// Optional feature macro: TFF_SCHED_STATS_EN (live saturating pulse_cnt; else tied to 0).
module tff_pulse_sched #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned SEP_CYC = 10,
   parameter int unsigned PULSE_W = 2,
   parameter int unsigned CNT_W   = 8
) (
   input logic              clk,
   input logic              rst,
   tff_pulse_sched_if.slave bus
);

   localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned TMR_W = $clog2(SEP_CYC);
   localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_W - 1);
   localparam logic [TMR_W-1:0] SEP_LAST   = TMR_W'(SEP_CYC - PULSE_W - 1);

   typedef enum logic [1:0] {StIdle, StPulse, StSep} state_e;

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic             t_pulse_q, t_pulse_d;
   logic             busy_q, busy_d;
   logic             t_state_q, t_state_d;

   logic             win_found;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] scan_idx;
   logic             issue;

   // Round-robin search: first set req bit at or above the pointer, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         scan_idx = PTR_W'((32'(ptr_q) + i) % N_REQ);
         if (!win_found && bus.req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   // Next-state logic; req is only looked at in IDLE and on the last SEP cycle.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      ptr_d   = ptr_q;
      issue   = 1'b0;
      unique case (state_q)
         StIdle: begin
            issue = win_found;
         end
         StPulse: begin
            if (tmr_q == PULSE_LAST) begin
               state_d = StSep;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         StSep: begin
            if (tmr_q == SEP_LAST) begin
               if (win_found) begin
                  issue = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (issue) begin
         state_d = StPulse;
         tmr_d   = '0;
         ptr_d   = (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
      end
   end

   // Registered outputs follow the next state so they line up with the grant edge.
   always_comb begin
      gnt_d     = issue ? (N_REQ'(1) << win_idx) : '0;
      t_pulse_d = (state_d == StPulse);
      busy_d    = (state_d != StIdle);
      t_state_d = t_state_q ^ issue;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         tmr_q     <= '0;
         ptr_q     <= '0;
         gnt_q     <= '0;
         t_pulse_q <= 1'b0;
         busy_q    <= 1'b0;
         t_state_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         t_pulse_q <= t_pulse_d;
         busy_q    <= busy_d;
         t_state_q <= t_state_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.t_pulse = t_pulse_q;
   assign bus.busy    = busy_q;
   assign bus.t_state = t_state_q;

`ifdef TFF_SCHED_STATS_EN
   logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;

   // Saturating count of issued pulses; holds at all-ones.
   always_comb begin
      pulse_cnt_d = pulse_cnt_q;
      if (issue && (pulse_cnt_q != '1)) begin
         pulse_cnt_d = pulse_cnt_q + 1'b1;
      end
   end

   // Pulse counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pulse_cnt_q <= '0;
      end else begin
         pulse_cnt_q <= pulse_cnt_d;
      end
   end

   assign bus.pulse_cnt = pulse_cnt_q;
`else
   assign bus.pulse_cnt = '0;
`endif

endmodule
